// File: rtl/vga_test_pattern.sv
// vga_test_pattern: 640x480@60 VGA timing generator with colour bars and a button-driven inverted box.
// Ports:
//   clk         25 MHz pixel clock
//   rst         asynchronous, active-low reset
//   bntr, bntl  move-right / move-left buttons, active-high, asynchronous to clk
//   VGA_Hsync_n, VGA_Vsync_n  active-low syncs, registered
//   VGA_R, VGA_G, VGA_B       1-bit colour channels, registered
//   clkout      combinational copy of clk
// Optional: define BORDER_EN to draw a one-pixel white frame around the visible area.
module vga_test_pattern #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int BOX_SIZE  = 32,
    parameter int STEP      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic bntr,
    input  logic bntl,
    output logic VGA_Hsync_n,
    output logic VGA_Vsync_n,
    output logic VGA_R,
    output logic VGA_G,
    output logic VGA_B,
    output logic clkout
);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] V_MOVE   = 10'(V_VISIBLE - 1);
    localparam logic [9:0] BAR_W    = 10'(H_VISIBLE / 8);
    localparam logic [9:0] BOX_Y0   = 10'((V_VISIBLE - BOX_SIZE) / 2);
    localparam logic [9:0] BOX_Y1   = 10'((V_VISIBLE + BOX_SIZE) / 2);
    localparam logic [10:0] BOX_W   = 11'(BOX_SIZE);
    localparam logic [9:0] X_MAX    = 10'(H_VISIBLE - BOX_SIZE);
    localparam logic [9:0] X_RST    = 10'((H_VISIBLE - BOX_SIZE) / 2);
    localparam logic [9:0] STEP_W   = 10'(STEP);

    logic [9:0]  h_cnt, v_cnt, box_x, box_nx;
    logic [10:0] step_r;
    logic [1:0]  r_sync, l_sync;
    logic [2:0]  bar, rgb;
    logic        line_end, visible, in_box, border, move_r, move_l;

    assign clkout   = clk;
    assign line_end = h_cnt == H_LAST;
    assign visible  = h_cnt < H_VIS && v_cnt < V_VIS;
    assign bar      = 3'(h_cnt / BAR_W);
    // Box end compared in 11 bits so box_x + BOX_SIZE cannot wrap.
    assign in_box   = h_cnt >= box_x && {1'b0, h_cnt} < {1'b0, box_x} + BOX_W &&
                      v_cnt >= BOX_Y0 && v_cnt < BOX_Y1;
`ifdef BORDER_EN
    assign border   = visible && (h_cnt == 10'd0 || h_cnt == H_VIS - 10'd1 ||
                                  v_cnt == 10'd0 || v_cnt == V_VIS - 10'd1);
`else
    assign border   = 1'b0;
`endif
    assign rgb      = !visible ? 3'b000 : border ? 3'b111 : in_box ? ~bar : bar;

    // Pressing both buttons cancels out; left clamps before subtracting to avoid underflow.
    assign move_r   = r_sync[1] & ~l_sync[1];
    assign move_l   = l_sync[1] & ~r_sync[1];
    assign step_r   = {1'b0, box_x} + {1'b0, STEP_W};
    assign box_nx   = move_r ? (step_r > {1'b0, X_MAX} ? X_MAX : step_r[9:0]) :
                      move_l ? (box_x < STEP_W ? 10'd0 : box_x - STEP_W) : box_x;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            box_x       <= X_RST;
            r_sync      <= '0;
            l_sync      <= '0;
            VGA_Hsync_n <= 1'b1;
            VGA_Vsync_n <= 1'b1;
            {VGA_R, VGA_G, VGA_B} <= 3'b000;
        end else begin
            r_sync <= {r_sync[0], bntr};
            l_sync <= {l_sync[0], bntl};
            h_cnt  <= line_end ? '0 : h_cnt + 10'd1;
            if (line_end)
                v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + 10'd1;
            // Counters are about to enter (V_VISIBLE, 0): once-per-frame box update.
            if (line_end && v_cnt == V_MOVE)
                box_x <= box_nx;
            VGA_Hsync_n <= !(h_cnt >= HS_FIRST && h_cnt <= HS_LAST);
            VGA_Vsync_n <= !(v_cnt >= VS_FIRST && v_cnt <= VS_LAST);
            {VGA_R, VGA_G, VGA_B} <= rgb;
        end
    end
endmodule

// File: tb/tb_vga_test_pattern.sv
// tb_vga_test_pattern: directed checks of a full-size and a reduced-size vga_test_pattern.
module tb_vga_test_pattern;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic bntr = 1'b0;
    logic bntl = 1'b0;
    logic f_hs, f_vs, f_r, f_g, f_b, f_clko;
    logic s_hs, s_vs, s_r, s_g, s_b, s_clko;
    int   n = 0;
    int   bxs = 12;
    int   total = 0;
    int   bad = 0;

    always #20 clk = ~clk;

    vga_test_pattern dut_f (
        .clk(clk), .rst(rst), .bntr(bntr), .bntl(bntl),
        .VGA_Hsync_n(f_hs), .VGA_Vsync_n(f_vs),
        .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b), .clkout(f_clko)
    );

    // Small geometry: 40 clk lines, 20 line frames, 4-pixel bars, 8x8 box at rows 4..11.
    vga_test_pattern #(
        .H_VISIBLE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VISIBLE(16), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .BOX_SIZE(8), .STEP(2)
    ) dut_s (
        .clk(clk), .rst(rst), .bntr(bntr), .bntl(bntl),
        .VGA_Hsync_n(s_hs), .VGA_Vsync_n(s_vs),
        .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .clkout(s_clko)
    );

    // Expected {hsync_n, vsync_n, R, G, B} for the pixel at (h, v).
    function automatic logic [4:0] exp_out(int h, int v, int hv, int hfp, int hs,
                                           int vv, int vfp, int vs, int bs, int bx);
        logic [2:0] c;
        logic       hsn, vsn, vis;
        int         y0;
        hsn = !(h >= hv + hfp && h < hv + hfp + hs);
        vsn = !(v >= vv + vfp && v < vv + vfp + vs);
        vis = h < hv && v < vv;
        c   = 3'(h / (hv / 8));
        y0  = (vv - bs) / 2;
        if (h >= bx && h < bx + bs && v >= y0 && v < y0 + bs) c = ~c;
`ifdef BORDER_EN
        if (h == 0 || h == hv - 1 || v == 0 || v == vv - 1) c = 3'b111;
`endif
        if (!vis) c = 3'b000;
        return {hsn, vsn, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        n = 0;
    endtask

    task automatic test_reset();
        #200;
        total++;
        if ({f_hs, f_vs, f_r, f_g, f_b} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_full got=%b exp=11000", {f_hs, f_vs, f_r, f_g, f_b});
        end
        total++;
        if ({s_hs, s_vs, s_r, s_g, s_b} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_small got=%b exp=11000", {s_hs, s_vs, s_r, s_g, s_b});
        end
        @(posedge clk);
        #1;
        total++;
        if (f_clko !== 1'b1) begin
            bad++;
            $display("FAIL clkout_high got=%b exp=1", f_clko);
        end
        @(negedge clk);
        #1;
        total++;
        if (f_clko !== 1'b0) begin
            bad++;
            $display("FAIL clkout_low got=%b exp=0", f_clko);
        end
    endtask

    // Two full-size lines: bars, blanking, hsync position/width and the 800 clk line period.
    task automatic test_line();
        logic [4:0] e, g;
        for (int k = 0; k < 1600; k++) begin
            tick();
            e = exp_out((n - 1) % 800, (n - 1) / 800, 640, 16, 96, 480, 10, 2, 32, 304);
            g = {f_hs, f_vs, f_r, f_g, f_b};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL line_full p=%0d got=%b exp=%b", n - 1, g, e);
            end
        end
    endtask

    // Small DUT: whole frames with buttons held per phase; model moves the box once per frame.
    task automatic test_box_move();
        int ph_r[5] = '{0, 1, 0, 1, 1};
        int ph_l[5] = '{0, 0, 1, 0, 1};
        int ph_f[5] = '{1, 3, 12, 15, 5};
        logic [4:0] e, g;
        int h, v;
        for (int i = 0; i < 5; i++) begin
            bntr = ph_r[i][0];
            bntl = ph_l[i][0];
            for (int k = 0; k < ph_f[i] * 800; k++) begin
                tick();
                h = (n - 1) % 40;
                v = ((n - 1) / 40) % 20;
                if (h == 0 && v == 16) begin
                    if (bntr && !bntl) bxs = (bxs + 2 > 24) ? 24 : bxs + 2;
                    if (bntl && !bntr) bxs = (bxs < 2) ? 0 : bxs - 2;
                end
                e = exp_out(h, v, 32, 2, 4, 16, 1, 2, 8, bxs);
                g = {s_hs, s_vs, s_r, s_g, s_b};
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL move_ph%0d p=%0d got=%b exp=%b", i, n - 1, g, e);
                end
            end
        end
        bntr = 1'b0;
        bntl = 1'b0;
    endtask

    // Reset mid-frame: outputs drop immediately, then the small frame restarts with the box centred.
    task automatic test_mid_reset();
        logic [4:0] e, g;
        for (int k = 0; k < 411; k++) tick();
        total++;
        if ({s_r, s_g, s_b} !== 3'b010) begin
            bad++;
            $display("FAIL pre_reset_rgb got=%b exp=010", {s_r, s_g, s_b});
        end
        #5;
        rst = 1'b0;
        #2;
        total++;
        if ({s_hs, s_vs, s_r, s_g, s_b} !== 5'b11000) begin
            bad++;
            $display("FAIL midreset_small got=%b exp=11000", {s_hs, s_vs, s_r, s_g, s_b});
        end
        total++;
        if ({f_hs, f_vs, f_r, f_g, f_b} !== 5'b11000) begin
            bad++;
            $display("FAIL midreset_full got=%b exp=11000", {f_hs, f_vs, f_r, f_g, f_b});
        end
        #100;
        release_reset();
        bxs = 12;
        for (int k = 0; k < 800; k++) begin
            tick();
            e = exp_out((n - 1) % 40, (n - 1) / 40, 32, 2, 4, 16, 1, 2, 8, bxs);
            g = {s_hs, s_vs, s_r, s_g, s_b};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL after_reset_small p=%0d got=%b exp=%b", n - 1, g, e);
            end
            e = exp_out((n - 1) % 800, 0, 640, 16, 96, 480, 10, 2, 32, 304);
            g = {f_hs, f_vs, f_r, f_g, f_b};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL after_reset_full p=%0d got=%b exp=%b", n - 1, g, e);
            end
        end
    endtask

    initial begin
        test_reset();
        release_reset();
        test_line();
        test_box_move();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
